readout_shot_sequencer: RTL and testbench

// Sequences a batch of single-shot readouts through the linear classifier datapath: accepts I/Q

---
 rtl/readout_shot_sequencer.sv | 168 ++++++++++++++++
 tb/tb_readout_shot_sequencer.sv | 493 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/readout_shot_sequencer.sv
// readout_shot_sequencer
// Walks a batch of single-shot readouts through the linear classifier. Each I/Q
// sample is handed over with a one-cycle data_in pulse. The sequencer then waits
// for the classifier result, or for a timeout, and scores the shot into one of
// four saturating tallies. A holdoff gap after each result gives the classifier
// time to return to idle before the next sample is accepted.
module readout_shot_sequencer #(
  parameter int SHOT_W  = 16,
  parameter int TIMEOUT = 8,
  parameter int HOLDOFF = 1
) (
  input  logic              i_clk100,
  input  logic              i_reset,
  input  logic              i_start,
  input  logic [SHOT_W-1:0] i_num_shots,
  input  logic              i_abort,
  input  logic              i_iq_valid,
  output logic              o_iq_ready,
  output logic              o_dp_data_in,
  input  logic              i_dp_valid,
  input  logic [1:0]        i_dp_state,
  output logic              o_busy,
  output logic              o_done,
  output logic [SHOT_W-1:0] o_shots_done,
  output logic [SHOT_W-1:0] o_ground_count,
  output logic [SHOT_W-1:0] o_excited_count,
  output logic [SHOT_W-1:0] o_line_count,
  output logic [SHOT_W-1:0] o_err_count
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_ARM  = 3'd1;
  localparam logic [2:0] S_WAIT = 3'd2;
  localparam logic [2:0] S_HOLD = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  // r_wait counts completed WAIT cycles; the shot expires on the cycle that
  // would take it to TIMEOUT, i.e. the TIMEOUT-th WAIT cycle.
  localparam int                WAIT_W    = $clog2(TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);
  localparam int                HOLD_W    = $clog2(HOLDOFF + 2);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'((HOLDOFF > 0) ? (HOLDOFF - 1) : 0);
  localparam logic              NO_HOLD   = (HOLDOFF == 0);

  logic [2:0]        r_state;
  logic [WAIT_W-1:0] r_wait;
  logic [HOLD_W-1:0] r_hold;
  logic [SHOT_W-1:0] r_num_shots;
  logic [SHOT_W-1:0] r_shots_done;
  logic [SHOT_W-1:0] r_ground;
  logic [SHOT_W-1:0] r_excited;
  logic [SHOT_W-1:0] r_line;
  logic [SHOT_W-1:0] r_err;

  logic w_iq_ready;
  logic w_accept;
  logic w_timeout;
  logic w_score;
  logic w_last_shot;

  // Saturating increment shared by every tally.
  function automatic logic [SHOT_W-1:0] sat_inc(input logic [SHOT_W-1:0] v);
    if (v == {SHOT_W{1'b1}}) begin
      sat_inc = v;
    end else begin
      sat_inc = v + SHOT_W'(1);
    end
  endfunction

  // Ready is withheld during reset or abort so that no classifier pulse
  // escapes on a cycle whose handshake the sequencer is about to discard.
  assign w_iq_ready  = (r_state == S_ARM) & ~i_reset & ~i_abort;
  assign w_accept    = w_iq_ready & i_iq_valid;
  assign w_timeout   = (r_wait == WAIT_LAST);
  assign w_score     = (r_state == S_WAIT) & ~i_abort & (i_dp_valid | w_timeout);
  assign w_last_shot = (r_shots_done == (r_num_shots - SHOT_W'(1)));

  assign o_iq_ready      = w_iq_ready;
  assign o_dp_data_in    = w_accept;
  assign o_busy          = (r_state == S_ARM) | (r_state == S_WAIT) | (r_state == S_HOLD);
  assign o_done          = (r_state == S_DONE);
  assign o_shots_done    = r_shots_done;
  assign o_ground_count  = r_ground;
  assign o_excited_count = r_excited;
  assign o_line_count    = r_line;
  assign o_err_count     = r_err;

  // Batch state machine, shot scoring and tally registers.
  always_ff @(posedge i_clk100) begin
    if (i_reset) begin
      r_state      <= S_IDLE;
      r_wait       <= '0;
      r_hold       <= '0;
      r_num_shots  <= '0;
      r_shots_done <= '0;
      r_ground     <= '0;
      r_excited    <= '0;
      r_line       <= '0;
      r_err        <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_num_shots  <= i_num_shots;
            r_shots_done <= '0;
            r_ground     <= '0;
            r_excited    <= '0;
            r_line       <= '0;
            r_err        <= '0;
            r_state      <= (i_num_shots == '0) ? S_DONE : S_ARM;
          end
        end
        S_ARM: begin
          if (i_abort) begin
            r_state <= S_IDLE;
          end else if (w_accept) begin
            r_wait  <= '0;
            r_state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (i_abort) begin
            r_state <= S_IDLE;
          end else if (w_score) begin
            r_shots_done <= sat_inc(r_shots_done);
            // A result on the expiry cycle still counts as a real result.
            if (i_dp_valid) begin
              case (i_dp_state)
                2'b01:   r_ground  <= sat_inc(r_ground);
                2'b10:   r_excited <= sat_inc(r_excited);
                2'b11:   r_line    <= sat_inc(r_line);
                default: r_err     <= sat_inc(r_err);
              endcase
            end else begin
              r_err <= sat_inc(r_err);
            end
            if (w_last_shot) begin
              r_state <= S_DONE;
            end else if (NO_HOLD) begin
              r_state <= S_ARM;
            end else begin
              r_hold  <= '0;
              r_state <= S_HOLD;
            end
          end else begin
            r_wait <= r_wait + WAIT_W'(1);
          end
        end
        S_HOLD: begin
          if (i_abort) begin
            r_state <= S_IDLE;
          end else if (r_hold == HOLD_LAST) begin
            r_state <= S_ARM;
          end else begin
            r_hold <= r_hold + HOLD_W'(1);
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_readout_shot_sequencer.sv
// Testbench for readout_shot_sequencer: a behavioural classifier answers each
// data_in pulse after a programmable latency, expected tallies are queued when a
// batch is launched, and they are compared when the batch ends.
module tb_readout_shot_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [15:0] num_shots = 16'd0;
  logic        abort = 1'b0;
  logic        iq_valid = 1'b0;
  logic        cls_valid = 1'b0;
  logic [1:0]  cls_state = 2'b00;
  logic        stray_valid = 1'b0;
  logic [1:0]  stray_state = 2'b00;
  wire         dp_valid = cls_valid | stray_valid;
  wire  [1:0]  dp_state = stray_valid ? stray_state : cls_state;
  wire         iq_ready, dp_data_in, busy, done;
  wire  [15:0] shots_done, ground_count, excited_count, line_count, err_count;

  int          n_checks = 0;
  int          n_errors = 0;
  int          cyc = 0;
  int          acc_q[$];
  int          done_cnt = 0;
  logic [1:0]  cls_q[$];
  logic [79:0] exp_q[$];
  bit          cls_en = 1'b1;
  bit          cls_long = 1'b0;
  int          cls_delay = 3;

  readout_shot_sequencer #(.SHOT_W(16), .TIMEOUT(8), .HOLDOFF(1)) dut (
    .i_clk100(clk), .i_reset(reset), .i_start(start), .i_num_shots(num_shots),
    .i_abort(abort), .i_iq_valid(iq_valid), .o_iq_ready(iq_ready),
    .o_dp_data_in(dp_data_in), .i_dp_valid(dp_valid), .i_dp_state(dp_state),
    .o_busy(busy), .o_done(done), .o_shots_done(shots_done),
    .o_ground_count(ground_count), .o_excited_count(excited_count),
    .o_line_count(line_count), .o_err_count(err_count)
  );

  initial forever #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Monitor: records accept cycles and done pulses.
  initial forever begin
    @(negedge clk);
    if (dp_data_in === 1'b1) acc_q.push_back(cyc);
    if (done === 1'b1) done_cnt++;
  end

  // Classifier model: answers each data_in pulse after cls_delay cycles.
  initial forever begin
    logic [1:0] st;
    @(negedge clk);
    if (dp_data_in === 1'b1 && cls_en) begin
      st = (cls_q.size() > 0) ? cls_q.pop_front() : 2'b00;
      repeat (cls_delay) @(posedge clk);
      #1;
      cls_state = st;
      cls_valid = 1'b1;
      @(posedge clk);
      if (cls_long) @(posedge clk);
      #1;
      cls_valid = 1'b0;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_batch(input logic [15:0] n, output int t_start);
    tick();
    start = 1'b1;
    num_shots = n;
    t_start = cyc;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit ok, output int at);
    ok = 1'b0;
    at = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        ok = 1'b1;
        at = cyc;
        break;
      end
    end
  endtask

  task automatic wait_accepts(input int count, input int budget, output bit ok);
    int seen;
    seen = 0;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (dp_data_in === 1'b1) seen++;
      if (seen == count) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    logic [79:0] got;
    reset = 1'b1;
    repeat (3) tick();
    @(negedge clk);
    n_checks++;
    if ({busy, done, iq_ready, dp_data_in} !== 4'b0000) begin
      n_errors++;
      $display("FAIL reset_ctrl got %b exp 0000", {busy, done, iq_ready, dp_data_in});
    end
    got = {shots_done, ground_count, excited_count, line_count, err_count};
    n_checks++;
    if (got !== 80'd0) begin
      n_errors++;
      $display("FAIL reset_counts got %h exp 0", got);
    end
    tick();
    reset = 1'b0;
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_idle_busy got %b exp 0", busy);
    end
  endtask

  task automatic test_classify();
    int ts, td;
    bit ok;
    logic [79:0] got, exp;
    iq_valid = 1'b1;
    acc_q.delete();
    cls_q = '{2'b01, 2'b10, 2'b10, 2'b11};
    exp_q.push_back({16'd4, 16'd1, 16'd2, 16'd1, 16'd0});
    start_batch(16'd4, ts);
    wait_done(200, ok, td);
    n_checks++;
    if (!ok) begin
      n_errors++;
      $display("FAIL classify_done got none exp pulse");
    end
    n_checks++;
    if (acc_q.size() != 4) begin
      n_errors++;
      $display("FAIL classify_pulses got %0d exp 4", acc_q.size());
    end
    if (acc_q.size() > 0) begin
      n_checks++;
      if (acc_q[0] != ts + 1) begin
        n_errors++;
        $display("FAIL classify_first_accept got %0d exp %0d", acc_q[0], ts + 1);
      end
      n_checks++;
      if (td != acc_q[acc_q.size() - 1] + 4) begin
        n_errors++;
        $display("FAIL classify_done_time got %0d exp %0d", td, acc_q[acc_q.size() - 1] + 4);
      end
    end
    got = {shots_done, ground_count, excited_count, line_count, err_count};
    exp = exp_q.pop_front();
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL classify_tally got %h exp %h", got, exp);
    end
    @(negedge clk);
    n_checks++;
    if ({done, busy} !== 2'b00) begin
      n_errors++;
      $display("FAIL classify_done_width got %b exp 00", {done, busy});
    end
  endtask

  task automatic test_timeout();
    int ts, td;
    bit ok;
    logic [79:0] got, exp;
    cls_en = 1'b0;
    acc_q.delete();
    exp_q.push_back({16'd2, 16'd0, 16'd0, 16'd0, 16'd2});
    start_batch(16'd2, ts);
    wait_done(200, ok, td);
    n_checks++;
    if (!ok || acc_q.size() != 2) begin
      n_errors++;
      $display("FAIL timeout_run got ok=%0d accepts=%0d exp ok=1 accepts=2", ok, acc_q.size());
    end else begin
      n_checks++;
      if (acc_q[1] - acc_q[0] != 10) begin
        n_errors++;
        $display("FAIL timeout_spacing got %0d exp 10", acc_q[1] - acc_q[0]);
      end
      n_checks++;
      if (td - acc_q[1] != 9) begin
        n_errors++;
        $display("FAIL timeout_done_time got %0d exp 9", td - acc_q[1]);
      end
    end
    got = {shots_done, ground_count, excited_count, line_count, err_count};
    exp = exp_q.pop_front();
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL timeout_tally got %h exp %h", got, exp);
    end
    cls_en = 1'b1;
    repeat (2) tick();
  endtask

  task automatic test_expiry_edge();
    int ts, td;
    bit ok;
    logic [79:0] got, exp;
    cls_delay = 8;
    acc_q.delete();
    cls_q = '{2'b10};
    exp_q.push_back({16'd1, 16'd0, 16'd1, 16'd0, 16'd0});
    start_batch(16'd1, ts);
    wait_done(100, ok, td);
    n_checks++;
    if (!ok || acc_q.size() != 1 || td - acc_q[0] != 9) begin
      n_errors++;
      $display("FAIL expiry_done_time got ok=%0d delta=%0d exp ok=1 delta=9", ok,
               (acc_q.size() > 0) ? td - acc_q[0] : -1);
    end
    got = {shots_done, ground_count, excited_count, line_count, err_count};
    exp = exp_q.pop_front();
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL expiry_tally got %h exp %h", got, exp);
    end
    cls_delay = 3;
    repeat (3) tick();
  endtask

  task automatic test_back_to_back();
    int ts, td;
    bit ok;
    logic [79:0] got, exp;
    cls_long = 1'b1;
    acc_q.delete();
    cls_q = '{2'b01, 2'b01, 2'b00};
    exp_q.push_back({16'd3, 16'd2, 16'd0, 16'd0, 16'd1});
    start_batch(16'd3, ts);
    wait_done(200, ok, td);
    n_checks++;
    if (!ok || acc_q.size() != 3) begin
      n_errors++;
      $display("FAIL b2b_pulses got ok=%0d accepts=%0d exp ok=1 accepts=3", ok, acc_q.size());
    end else begin
      n_checks++;
      if (acc_q[1] - acc_q[0] != 5 || acc_q[2] - acc_q[1] != 5) begin
        n_errors++;
        $display("FAIL b2b_spacing got %0d,%0d exp 5,5", acc_q[1] - acc_q[0], acc_q[2] - acc_q[1]);
      end
    end
    exp = exp_q.pop_front();
    got = {shots_done, ground_count, excited_count, line_count, err_count};
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL b2b_tally got %h exp %h", got, exp);
    end
    repeat (3) tick();
    @(negedge clk);
    got = {shots_done, ground_count, excited_count, line_count, err_count};
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL b2b_late_valid got %h exp %h", got, exp);
    end
    cls_long = 1'b0;
  endtask

  task automatic test_abort();
    int ts, td, d0;
    bit ok;
    logic [79:0] got, exp;
    acc_q.delete();
    cls_q = '{2'b01, 2'b10, 2'b11, 2'b01, 2'b01};
    exp_q.push_back({16'd2, 16'd1, 16'd1, 16'd0, 16'd0});
    d0 = done_cnt;
    start_batch(16'd5, ts);
    wait_accepts(3, 200, ok);
    n_checks++;
    if (!ok) begin
      n_errors++;
      $display("FAIL abort_reach_shot3 got none exp accept");
    end
    tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b0) begin
      n_errors++;
      $display("FAIL abort_idle got busy=%b exp 0", busy);
    end
    repeat (6) tick();
    n_checks++;
    if (done_cnt != d0) begin
      n_errors++;
      $display("FAIL abort_no_done got %0d exp %0d", done_cnt, d0);
    end
    got = {shots_done, ground_count, excited_count, line_count, err_count};
    exp = exp_q.pop_front();
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL abort_partial got %h exp %h", got, exp);
    end
    cls_q.delete();
    cls_q.push_back(2'b10);
    exp_q.push_back({16'd1, 16'd0, 16'd1, 16'd0, 16'd0});
    start_batch(16'd1, ts);
    @(negedge clk);
    got = {shots_done, ground_count, excited_count, line_count, err_count};
    n_checks++;
    if (got !== 80'd0 || busy !== 1'b1) begin
      n_errors++;
      $display("FAIL abort_restart_clear got %h busy=%b exp 0 busy=1", got, busy);
    end
    wait_done(100, ok, td);
    got = {shots_done, ground_count, excited_count, line_count, err_count};
    exp = exp_q.pop_front();
    n_checks++;
    if (!ok || got !== exp) begin
      n_errors++;
      $display("FAIL abort_restart_tally got ok=%0d %h exp ok=1 %h", ok, got, exp);
    end
    repeat (3) tick();
  endtask

  task automatic test_zero_and_ignored();
    int ts, td, d0;
    bit ok;
    logic [79:0] got, exp;
    exp_q.push_back(80'd0);
    start_batch(16'd0, ts);
    wait_done(5, ok, td);
    n_checks++;
    if (!ok || td != ts + 1) begin
      n_errors++;
      $display("FAIL zero_done_time got ok=%0d at=%0d exp ok=1 at=%0d", ok, td, ts + 1);
    end
    got = {shots_done, ground_count, excited_count, line_count, err_count};
    exp = exp_q.pop_front();
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL zero_tally got %h exp %h", got, exp);
    end
    tick();
    stray_state = 2'b01;
    stray_valid = 1'b1;
    tick();
    stray_valid = 1'b0;
    @(negedge clk);
    got = {shots_done, ground_count, excited_count, line_count, err_count};
    n_checks++;
    if (got !== 80'd0) begin
      n_errors++;
      $display("FAIL stray_valid_idle got %h exp 0", got);
    end
    cls_q = '{2'b01, 2'b01};
    exp_q.push_back({16'd2, 16'd2, 16'd0, 16'd0, 16'd0});
    d0 = done_cnt;
    start_batch(16'd2, ts);
    tick();
    tick();
    start = 1'b1;
    num_shots = 16'd7;
    tick();
    start = 1'b0;
    wait_done(200, ok, td);
    got = {shots_done, ground_count, excited_count, line_count, err_count};
    exp = exp_q.pop_front();
    n_checks++;
    if (!ok || got !== exp) begin
      n_errors++;
      $display("FAIL start_while_busy got ok=%0d %h exp ok=1 %h", ok, got, exp);
    end
    start = 1'b1;
    num_shots = 16'd3;
    tick();
    start = 1'b0;
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b0) begin
      n_errors++;
      $display("FAIL start_in_done got busy=%b exp 0", busy);
    end
    n_checks++;
    if (done_cnt != d0 + 1) begin
      n_errors++;
      $display("FAIL done_pulse_count got %0d exp %0d", done_cnt, d0 + 1);
    end
    repeat (3) tick();
  endtask

  task automatic test_reset_mid();
    int ts, td;
    bit ok;
    logic [79:0] got, exp;
    iq_valid = 1'b0;
    start_batch(16'd1, ts);
    @(negedge clk);
    n_checks++;
    if (iq_ready !== 1'b1) begin
      n_errors++;
      $display("FAIL arm_ready got %b exp 1", iq_ready);
    end
    tick();
    reset = 1'b1;
    iq_valid = 1'b1;
    @(negedge clk);
    n_checks++;
    if (dp_data_in !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_cycle_data_in got %b exp 0", dp_data_in);
    end
    tick();
    reset = 1'b0;
    acc_q.delete();
    cls_q = '{2'b01, 2'b01, 2'b01};
    start_batch(16'd3, ts);
    wait_accepts(2, 200, ok);
    n_checks++;
    if (!ok) begin
      n_errors++;
      $display("FAIL resetmid_reach_shot2 got none exp accept");
    end
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    @(negedge clk);
    got = {shots_done, ground_count, excited_count, line_count, err_count};
    n_checks++;
    if ({busy, done, iq_ready, dp_data_in} !== 4'b0000 || got !== 80'd0) begin
      n_errors++;
      $display("FAIL resetmid_clear got ctrl=%b counts=%h exp 0000 0", {busy, done, iq_ready, dp_data_in}, got);
    end
    repeat (6) tick();
    cls_q.delete();
    cls_q.push_back(2'b11);
    exp_q.push_back({16'd1, 16'd0, 16'd0, 16'd1, 16'd0});
    start_batch(16'd1, ts);
    wait_done(100, ok, td);
    got = {shots_done, ground_count, excited_count, line_count, err_count};
    exp = exp_q.pop_front();
    n_checks++;
    if (!ok || got !== exp) begin
      n_errors++;
      $display("FAIL resetmid_recover got ok=%0d %h exp ok=1 %h", ok, got, exp);
    end
  endtask

  initial begin
    test_reset();
    test_classify();
    test_timeout();
    test_expiry_edge();
    test_back_to_back();
    test_abort();
    test_zero_and_ignored();
    test_reset_mid();
    repeat (2) tick();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
